interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1000000, cycles to wait in PRESENT for cpuAck before re-arbitration.
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 irqSignal  input  4  per-source interrupt request, active-low; bit i = source i.
REQ-005 irqIndex  input  16  per-source vector; bits [4i+3:4i] belong to source i, sampled with its request.
REQ-006 maskWrite  input  1  high for one cycle loads maskValue into the enable mask.
REQ-007 maskValue  input  4  new enable mask; 1 = source enabled.
REQ-008 cpuAck  input  1  CPU acknowledge, active-high, one cycle.
REQ-009 cpuInterrupt  output  1  interrupt to CPU, active-low, registered.
REQ-010 cpuIndex  output  4  vector of presented request, registered.
REQ-011 cpuSource  output  2  source number of presented request, registered.
REQ-012 pending  output  4  current pending-request register.

Function
REQ-013 Each cycle with irqSignal[i]==0 SHALL set pending[i] and latch irqIndex[4i+3:4i] into vector register i at that edge.
REQ-014 A new request on a source already pending SHALL overwrite its vector; pending stays 1.
REQ-015 States SHALL be IDLE, PRESENT and GAP.
REQ-016 IDLE: if (pending & mask) != 0, select lowest-numbered such source, load cpuIndex/cpuSource, drive cpuInterrupt=0, go to PRESENT; else hold cpuInterrupt=1.
REQ-017 Latency: request sampled at edge k -> pending set after edge k -> cpuInterrupt low after edge k+1 when IDLE and enabled.
REQ-018 PRESENT: cpuInterrupt, cpuIndex, cpuSource SHALL hold stable until cpuAck or timeout.
REQ-019 cpuAck in PRESENT SHALL clear pending[cpuSource], drive cpuInterrupt=1, go to GAP.
REQ-020 Ack coinciding with a new low request on the same source: set wins, pending stays 1 with new vector.
REQ-021 GAP SHALL last exactly one cycle with cpuInterrupt=1, then IDLE.
REQ-022 cpuAck in IDLE or GAP SHALL be ignored.
REQ-023 Mask writes take effect on the next edge; masking the presented source during PRESENT SHALL NOT abort the presentation.
REQ-024 Masked sources SHALL still latch into pending.
REQ-025 Wait counter SHALL clear on PRESENT entry and saturate, never wrap.

Reset
REQ-026 rst high at an edge SHALL force IDLE, pending=0, vectors=0, mask=4'b1111, counter=0, cpuInterrupt=1, cpuIndex=0, cpuSource=0, overriding all other inputs.
REQ-027 Reset mid-PRESENT SHALL discard the request; no ack is required afterwards.

Configuration
REQ-028 Macro INTC_TIMEOUT_EN.
REQ-029 Defined: if cpuAck absent for ACK_TIMEOUT cycles in PRESENT, drive cpuInterrupt=1, keep pending set, go to GAP, re-arbitrate.
REQ-030 Undefined: no counter logic; PRESENT waits indefinitely for cpuAck; ACK_TIMEOUT unused.

Verification
REQ-031 Source 1 pulses low one cycle, irqIndex[7:4]=4'h1 -> cpuInterrupt low two edges later, cpuIndex=1, cpuSource=1; ack -> high, pending=0.
REQ-032 Sources 0 and 3 pulse same cycle (vectors 4'h5, 4'hA) -> cpuIndex=5 first; after ack and one GAP cycle, cpuIndex=A.
REQ-033 maskValue=4'b1110 then source 0 request -> cpuInterrupt stays 1, pending=4'b0001; mask 4'b1111 -> presented.
REQ-034 Ack same cycle as new source-2 request (vector 4'h7) -> pending[2] remains 1, re-presented with cpuIndex=7 after GAP.
REQ-035 INTC_TIMEOUT_EN, ACK_TIMEOUT=8, no ack -> cpuInterrupt returns 1 after 8 cycles, one GAP, re-asserts same vector.
REQ-036 rst asserted during PRESENT -> next cycle cpuInterrupt=1, pending=0, mask=4'b1111.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller
// Four active-low interrupt sources are latched into a pending register
// together with a 4-bit vector each. A small arbiter presents the
// lowest-numbered pending and enabled source to the CPU, then waits for
// cpuAck, and inserts a one-cycle gap before it arbitrates again.
// Build option: define INTC_TIMEOUT_EN to give up on a presentation after
// ACK_TIMEOUT cycles without cpuAck. The source stays pending and is
// arbitrated again.
module interrupt_controller #(
    parameter int ACK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  irqSignal,
    input  logic [15:0] irqIndex,
    input  logic        maskWrite,
    input  logic [3:0]  maskValue,
    input  logic        cpuAck,
    output logic        cpuInterrupt,
    output logic [3:0]  cpuIndex,
    output logic [1:0]  cpuSource,
    output logic [3:0]  pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  pending_reg, pending_next;
    logic [3:0]  vector_reg  [4];
    logic [3:0]  vector_next [4];
    logic [3:0]  mask_reg;
    logic        int_reg, int_next;
    logic [3:0]  index_reg, index_next;
    logic [1:0]  source_reg, source_next;
    logic [3:0]  eligible;
    logic [1:0]  sel;
    logic        ack_clear;
    logic        timeout;

    // Only an acknowledge of a live presentation retires a pending bit
    assign ack_clear = (state_reg == PRESENT) && cpuAck;
    assign eligible  = pending_reg & mask_reg;

    // Per-source request capture. A new request beats a simultaneous ack
    // clear, so a re-raised source is never lost.
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
        assign pending_next[gi] = !irqSignal[gi] ? 1'b1 :
                                  (ack_clear && source_reg == 2'(gi)) ? 1'b0 :
                                  pending_reg[gi];
        assign vector_next[gi]  = !irqSignal[gi] ? irqIndex[4*gi +: 4] : vector_reg[gi];
    end

    // Pending bits, vectors and enable mask
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
            mask_reg    <= 4'b1111;
            for (int i = 0; i < 4; i++) vector_reg[i] <= '0;
        end else begin
            pending_reg <= pending_next;
            if (maskWrite) mask_reg <= maskValue;
            for (int i = 0; i < 4; i++) vector_reg[i] <= vector_next[i];
        end
    end

`ifdef INTC_TIMEOUT_EN
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    // Cycles spent in PRESENT. The counter is zero on entry because it is held
    // clear in every other state. It saturates at its last value.
    always_ff @(posedge clk) begin
        if (rst || state_reg != PRESENT) begin
            count_reg <= '0;
        end else if (count_reg != COUNT_LAST) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign timeout = (count_reg == COUNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Lowest-numbered eligible source wins
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) sel = 2'(i);
        end
    end

    // Arbiter next-state and registered CPU outputs
    always_comb begin
        state_next  = state_reg;
        int_next    = int_reg;
        index_next  = index_reg;
        source_next = source_reg;
        case (state_reg)
            IDLE: begin
                int_next = 1'b1;
                if (eligible != 4'b0000) begin
                    source_next = sel;
                    index_next  = vector_reg[sel];
                    int_next    = 1'b0;
                    state_next  = PRESENT;
                end
            end
            PRESENT: begin
                if (cpuAck || timeout) begin
                    int_next   = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                int_next   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                int_next   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            int_reg    <= 1'b1;
            index_reg  <= '0;
            source_reg <= '0;
        end else begin
            state_reg  <= state_next;
            int_reg    <= int_next;
            index_reg  <= index_next;
            source_reg <= source_next;
        end
    end

    assign cpuInterrupt = int_reg;
    assign cpuIndex     = index_reg;
    assign cpuSource    = source_reg;
    assign pending      = pending_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller
// Directed scenarios followed by random traffic. A behavioural model of the
// controller's rules is compared against the DUT after every clock edge.
// Timeout scenarios are built only when INTC_TIMEOUT_EN is defined.
module tb_interrupt_controller;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irqSignal;
    logic [15:0] irqIndex;
    logic        maskWrite;
    logic [3:0]  maskValue;
    logic        cpuAck;
    logic        cpuInterrupt;
    logic [3:0]  cpuIndex;
    logic [1:0]  cpuSource;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [3:0] m_pending;
    logic [3:0] m_vec [4];
    logic [3:0] m_mask;
    bit         m_presenting;
    bit         m_gap;
    int         m_wait;
    logic       m_int;
    logic [3:0] m_idx;
    logic [1:0] m_src;

    interrupt_controller #(.ACK_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .irqSignal    (irqSignal),
        .irqIndex     (irqIndex),
        .maskWrite    (maskWrite),
        .maskValue    (maskValue),
        .cpuAck       (cpuAck),
        .cpuInterrupt (cpuInterrupt),
        .cpuIndex     (cpuIndex),
        .cpuSource    (cpuSource),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the controller's rules for one clock edge to the model
    task automatic model_edge(input logic [3:0] irq, input logic [15:0] idx,
                              input logic mw, input logic [3:0] mv,
                              input logic ack, input logic r);
        logic [3:0] old_pending;
        logic [3:0] old_mask;
        logic [3:0] old_vec [4];
        logic [3:0] new_pending;
        int         found;
        if (r) begin
            m_pending = '0; m_mask = 4'b1111;
            for (int i = 0; i < 4; i++) m_vec[i] = '0;
            m_presenting = 0; m_gap = 0; m_wait = 0;
            m_int = 1'b1; m_idx = '0; m_src = '0;
            return;
        end
        old_pending = m_pending;
        old_mask    = m_mask;
        old_vec     = m_vec;
        new_pending = old_pending;
        if (m_presenting && ack) new_pending[m_src] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!irq[i]) begin
                new_pending[i] = 1'b1;
                m_vec[i] = idx[4*i +: 4];
            end
        end
        if (mw) m_mask = mv;
        if (m_gap) begin
            m_gap = 0;
            m_int = 1'b1;
        end else if (m_presenting) begin
            if (ack) begin
                m_presenting = 0; m_gap = 1; m_int = 1'b1;
            end
`ifdef INTC_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait >= TO) begin
                    m_presenting = 0; m_gap = 1; m_int = 1'b1;
                end
            end
`endif
        end else begin
            found = -1;
            for (int i = 0; i < 4; i++)
                if (found < 0 && old_pending[i] && old_mask[i]) found = i;
            if (found >= 0) begin
                m_src = 2'(found);
                m_idx = old_vec[found];
                m_int = 1'b0;
                m_presenting = 1;
                m_wait = 0;
            end
        end
        m_pending = new_pending;
    endtask

    // One clock: drive, edge, update model, compare
    task automatic step(input logic [3:0] irq, input logic [15:0] idx,
                        input logic mw, input logic [3:0] mv,
                        input logic ack, input logic r);
        irqSignal = irq; irqIndex = idx; maskWrite = mw; maskValue = mv;
        cpuAck = ack; rst = r;
        @(posedge clk);
        model_edge(irq, idx, mw, mv, ack, r);
        #1;
        check("cpuInterrupt", 32'(cpuInterrupt), 32'(m_int));
        check("cpuIndex",     32'(cpuIndex),     32'(m_idx));
        check("cpuSource",    32'(cpuSource),    32'(m_src));
        check("pending",      32'(pending),      32'(m_pending));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'hF, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic ack1();
        step(4'hF, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        step(4'hF, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'h0, 16'hFFFF, 1'b1, 4'h0, 1'b1, 1'b1);
        check("reset_int", 32'(cpuInterrupt), 32'h1);
        check("reset_pending", 32'(pending), 32'h0);

        // Single source 1 with vector 1
        step(4'b1101, 16'h0010, 1'b0, 4'h0, 1'b0, 1'b0);
        check("s1_pending", 32'(pending), 32'h2);
        check("s1_not_yet", 32'(cpuInterrupt), 32'h1);
        idle(1);
        check("s1_int", 32'(cpuInterrupt), 32'h0);
        check("s1_idx", 32'(cpuIndex), 32'h1);
        check("s1_src", 32'(cpuSource), 32'h1);
        ack1();
        check("s1_ack_int", 32'(cpuInterrupt), 32'h1);
        check("s1_ack_pending", 32'(pending), 32'h0);
        idle(3);

        // Sources 0 and 3 together: 0 first, then 3 after the gap
        step(4'b0110, 16'hA005, 1'b0, 4'h0, 1'b0, 1'b0);
        idle(1);
        check("pri_first", 32'(cpuIndex), 32'h5);
        ack1();
        idle(1);
        check("pri_gap", 32'(cpuInterrupt), 32'h1);
        idle(1);
        check("pri_second", 32'(cpuIndex), 32'hA);
        check("pri_second_int", 32'(cpuInterrupt), 32'h0);
        ack1();
        idle(3);

        // Masked source still pends, presented once enabled
        step(4'hF, 16'h0000, 1'b1, 4'b1110, 1'b0, 1'b0);
        step(4'b1110, 16'h0003, 1'b0, 4'h0, 1'b0, 1'b0);
        idle(3);
        check("mask_hold", 32'(cpuInterrupt), 32'h1);
        check("mask_pending", 32'(pending), 32'h1);
        step(4'hF, 16'h0000, 1'b1, 4'b1111, 1'b0, 1'b0);
        idle(1);
        check("mask_present", 32'(cpuInterrupt), 32'h0);
        ack1();
        idle(3);

        // Ack coinciding with a new request on the presented source
        step(4'b1011, 16'h0300, 1'b0, 4'h0, 1'b0, 1'b0);
        idle(1);
        check("race_first", 32'(cpuIndex), 32'h3);
        step(4'b1011, 16'h0700, 1'b0, 4'h0, 1'b1, 1'b0);
        check("race_pending", 32'(pending[2]), 32'h1);
        idle(2);
        check("race_represent", 32'(cpuIndex), 32'h7);
        check("race_int", 32'(cpuInterrupt), 32'h0);
        ack1();
        idle(3);

`ifdef INTC_TIMEOUT_EN
        // No ack: presentation ends after TO cycles and the vector returns
        step(4'b1101, 16'h0090, 1'b0, 4'h0, 1'b0, 1'b0);
        idle(1);
        idle(TO - 1);
        check("to_still_low", 32'(cpuInterrupt), 32'h0);
        idle(1);
        check("to_released", 32'(cpuInterrupt), 32'h1);
        check("to_pending", 32'(pending), 32'h2);
        idle(2);
        check("to_again_int", 32'(cpuInterrupt), 32'h0);
        check("to_again_idx", 32'(cpuIndex), 32'h9);
        ack1();
        idle(3);
`endif

        // Reset during a presentation discards everything, mask back to all-on
        step(4'hF, 16'h0000, 1'b1, 4'b0001, 1'b0, 1'b0);
        step(4'b0110, 16'hB004, 1'b0, 4'h0, 1'b0, 1'b0);
        idle(1);
        check("rst_pre_src", 32'(cpuSource), 32'h0);
        step(4'b0000, 16'hFFFF, 1'b0, 4'h0, 1'b0, 1'b1);
        check("rst_int", 32'(cpuInterrupt), 32'h1);
        check("rst_pending", 32'(pending), 32'h0);
        step(4'b0111, 16'hC000, 1'b0, 4'h0, 1'b0, 1'b0);
        idle(1);
        check("rst_mask_src", 32'(cpuSource), 32'h3);
        ack1();
        idle(3);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] irq;
            irq = 4'hF;
            for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irq[b] = 1'b0;
            step(irq, 16'($urandom),
                 ($urandom_range(19) == 0), 4'($urandom),
                 ($urandom_range(2) == 0), ($urandom_range(299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
